// File: rtl/sprite_plotter_if.sv
// Request/pixel bus between a sprite client and the plotter, plus the VGA-adapter pixel outputs.
interface sprite_plotter_if;
  logic       start;
  logic [7:0] x_new;
  logic [6:0] y_new;
  logic [2:0] colour_new;
  logic       busy;
  logic       done;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;

  modport master (
    output start, x_new, y_new, colour_new,
    input  busy, done, x_out, y_out, colour_out, plot
  );

  modport slave (
    input  start, x_new, y_new, colour_new,
    output busy, done, x_out, y_out, colour_out, plot
  );
endinterface

// File: rtl/sprite_plotter.sv
// Moves a solid SPR_W x SPR_H sprite: erases the old footprint in background colour,
// then draws the new one, one pixel per cycle in raster order with frame-edge clipping.
module sprite_plotter #(
  parameter int unsigned SPR_W     = 4,
  parameter int unsigned SPR_H     = 4,
  parameter logic [2:0]  BG_COLOUR = 3'b000,
  parameter int unsigned X_MAX     = 159,
  parameter int unsigned Y_MAX     = 119
) (
  input  logic            clk,
  input  logic            resetn,
  sprite_plotter_if.slave bus
);

  localparam int unsigned XW     = 8;
  localparam int unsigned YW     = 7;
  localparam int unsigned CW     = 3;
  localparam int unsigned NPIX   = SPR_W * SPR_H;
  localparam int unsigned KW     = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NPIX - 1);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  typedef struct packed {
    logic          plot;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } pix_t;

  state_t        state;
  logic [KW-1:0] k;
  logic          old_valid;
  logic [XW-1:0] x_old, x_lat;
  logic [YW-1:0] y_old, y_lat;
  logic [CW-1:0] c_lat;

  logic          busy_q, done_q, plot_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [CW-1:0] c_q;

  logic [KW-1:0] k_nxt;
  pix_t          px_old, px_lat, px_old0, px_new0;

  // Sums are one bit wider than the port so overflow past the frame is seen as clipped.
  function automatic pix_t pixel(input logic [XW-1:0] bx, input logic [YW-1:0] by,
                                 input logic [KW-1:0] kk);
    logic [XW:0] xs;
    logic [YW:0] ys;
    pix_t        p;
    xs     = {1'b0, bx} + (XW+1)'(32'(kk) % SPR_W);
    ys     = {1'b0, by} + (YW+1)'(32'(kk) / SPR_W);
    p.plot = (xs <= (XW+1)'(X_MAX)) && (ys <= (YW+1)'(Y_MAX));
    p.x    = xs[XW-1:0];
    p.y    = ys[YW-1:0];
    return p;
  endfunction

  // Outputs are registered, so each edge loads the pixel for the index about to be shown.
  always_comb begin
    k_nxt   = (k == K_LAST) ? '0 : k + KW'(1);
    px_old  = pixel(x_old, y_old, k_nxt);
    px_lat  = pixel(x_lat, y_lat, k_nxt);
    px_old0 = pixel(x_old, y_old, '0);
    px_new0 = pixel(bus.x_new, bus.y_new, '0);
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state     <= IDLE;
      k         <= '0;
      old_valid <= 1'b0;
      x_old     <= '0;
      y_old     <= '0;
      x_lat     <= '0;
      y_lat     <= '0;
      c_lat     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      plot_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      c_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            x_lat  <= bus.x_new;
            y_lat  <= bus.y_new;
            c_lat  <= bus.colour_new;
            busy_q <= 1'b1;
            k      <= '0;
            if (old_valid && ((bus.x_new != x_old) || (bus.y_new != y_old))) begin
              state  <= ERASE;
              x_q    <= px_old0.x;
              y_q    <= px_old0.y;
              c_q    <= BG_COLOUR;
              plot_q <= px_old0.plot;
            end else begin
              state  <= DRAW;
              x_q    <= px_new0.x;
              y_q    <= px_new0.y;
              c_q    <= bus.colour_new;
              plot_q <= px_new0.plot;
            end
          end
        end
        ERASE: begin
          k <= k_nxt;
          if (k == K_LAST) begin
            state  <= DRAW;
            x_q    <= px_lat.x;
            y_q    <= px_lat.y;
            c_q    <= c_lat;
            plot_q <= px_lat.plot;
          end else begin
            x_q    <= px_old.x;
            y_q    <= px_old.y;
            c_q    <= BG_COLOUR;
            plot_q <= px_old.plot;
          end
        end
        DRAW: begin
          if (k == K_LAST) begin
            state  <= DONE;
            k      <= '0;
            done_q <= 1'b1;
            x_q    <= '0;
            y_q    <= '0;
            c_q    <= '0;
            plot_q <= 1'b0;
          end else begin
            k      <= k_nxt;
            x_q    <= px_lat.x;
            y_q    <= px_lat.y;
            c_q    <= c_lat;
            plot_q <= px_lat.plot;
          end
        end
        DONE: begin
          state     <= IDLE;
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
          x_old     <= x_lat;
          y_old     <= y_lat;
          old_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.plot       = plot_q;
  assign bus.x_out      = x_q;
  assign bus.y_out      = y_q;
  assign bus.colour_out = c_q;

endmodule

// File: tb/tb_sprite_plotter.sv
// Scoreboard bench for sprite_plotter: a footprint-level model queues the expected pixel
// stream per request; a negedge monitor compares every cycle the DUT presents.
module tb_sprite_plotter;

  localparam int SPR_W = 4;
  localparam int SPR_H = 4;
  localparam int XMAX  = 159;
  localparam int YMAX  = 119;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  sprite_plotter_if bif ();

  sprite_plotter #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .BG_COLOUR(3'b000), .X_MAX(XMAX), .Y_MAX(YMAX)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_done;
    bit         plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  // Reference: what the frame buffer should see for a request, as a list of footprint pixels.
  int m_x = 0, m_y = 0;
  bit m_valid = 1'b0;

  task automatic push_footprint(input int bx, input int by, input int col, input int acc,
                                inout int n);
    exp_t e;
    for (int dy = 0; dy < SPR_H; dy++) begin
      for (int dx = 0; dx < SPR_W; dx++) begin
        e.is_done = 1'b0;
        e.plot    = (bx + dx <= XMAX) && (by + dy <= YMAX);
        e.x       = 8'(bx + dx);
        e.y       = 7'(by + dy);
        e.c       = 3'(col);
        e.cyc     = acc + n;
        exp_q.push_back(e);
        n++;
      end
    end
  endtask

  task automatic model_req(input int x, input int y, input int col, input int acc);
    int   n = 0;
    exp_t e;
    if (m_valid && (x != m_x || y != m_y)) push_footprint(m_x, m_y, 0, acc, n);
    push_footprint(x, y, col, acc, n);
    e.is_done = 1'b1;
    e.plot    = 1'b0;
    e.x       = '0;
    e.y       = '0;
    e.c       = '0;
    e.cyc     = acc + n;
    exp_q.push_back(e);
    m_x = x;
    m_y = y;
    m_valid = 1'b1;
  endtask

  // Called at a negedge while idle; start is sampled on the coming posedge.
  task automatic issue(input int x, input int y, input int col);
    model_req(x, y, col, cyc + 1);
    bif.start      = 1'b1;
    bif.x_new      = 8'(x);
    bif.y_new      = 7'(y);
    bif.colour_new = 3'(col);
    @(negedge clk);
    bif.start      = 1'b0;
    bif.x_new      = 8'($urandom);
    bif.y_new      = 7'($urandom);
    bif.colour_new = 3'($urandom);
  endtask

  task automatic stray_start();
    bif.start      = 1'b1;
    bif.x_new      = 8'($urandom);
    bif.y_new      = 7'($urandom);
    bif.colour_new = 3'($urandom);
    @(negedge clk);
    bif.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bif.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      compared++;
      mismatched++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", bif.busy, n);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        if (!bif.busy) begin
          compared++;
          if (bif.done || bif.plot || bif.x_out != 0 || bif.y_out != 0 || bif.colour_out != 0) begin
            mismatched++;
            $display("FAIL idle_outputs @cyc %0d: done=%0b plot=%0b x=%0d y=%0d c=%0b, required all 0",
                     cyc, bif.done, bif.plot, bif.x_out, bif.y_out, bif.colour_out);
          end
        end else if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_activity @cyc %0d: busy=1 done=%0b plot=%0b x=%0d y=%0d, required idle",
                   cyc, bif.done, bif.plot, bif.x_out, bif.y_out);
        end else if (bif.done) begin
          e = exp_q.pop_front();
          compared++;
          if (!e.is_done || e.cyc != cyc || bif.plot || bif.x_out != 0 || bif.y_out != 0 ||
              bif.colour_out != 0) begin
            mismatched++;
            $display("FAIL done_pulse @cyc %0d: plot=%0b x=%0d y=%0d c=%0b, required done at cyc %0d (head is_done=%0b) outputs 0",
                     cyc, bif.plot, bif.x_out, bif.y_out, bif.colour_out, e.cyc, e.is_done);
          end
        end else begin
          e = exp_q.pop_front();
          compared++;
          if (e.is_done || e.cyc != cyc || e.plot != bif.plot || e.x != bif.x_out ||
              e.y != bif.y_out || e.c != bif.colour_out) begin
            mismatched++;
            $display("FAIL pixel @cyc %0d: got plot=%0b x=%0d y=%0d c=%0b, required done=%0b cyc=%0d plot=%0b x=%0d y=%0d c=%0b",
                     cyc, bif.plot, bif.x_out, bif.y_out, bif.colour_out,
                     e.is_done, e.cyc, e.plot, e.x, e.y, e.c);
          end
        end
      end
    end
  end

  // Driver
  initial begin
    int x, y, col, r;
    bif.start      = 1'b0;
    bif.x_new      = '0;
    bif.y_new      = '0;
    bif.colour_new = '0;
    repeat (3) @(negedge clk);
    compared++;
    if (bif.busy || bif.done || bif.plot || bif.x_out != 0 || bif.y_out != 0 || bif.colour_out != 0) begin
      mismatched++;
      $display("FAIL reset_state: busy=%0b done=%0b plot=%0b x=%0d y=%0d c=%0b, required all 0",
               bif.busy, bif.done, bif.plot, bif.x_out, bif.y_out, bif.colour_out);
    end
    resetn = 1'b0;
    repeat (2) @(negedge clk);

    // Directed: first draw, move with erase, same-position recolour, clipped corner.
    issue(10, 20, 3'b100);  wait_idle();
    issue(11, 20, 3'b100);  wait_idle();
    issue(11, 20, 3'b010);  wait_idle();
    issue(158, 118, 3'b111); wait_idle();

    // Randomized requests, back-to-back or gapped, some with ignored stray starts.
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      r = int'($urandom_range(0, 3));
      case (r)
        0:       begin x = m_x; y = m_y; end
        1:       begin x = int'($urandom_range(150, 170)); y = int'($urandom_range(110, 127)); end
        2:       begin x = int'($urandom_range(0, XMAX)); y = int'($urandom_range(0, YMAX)); end
        default: begin x = int'($urandom_range(0, 255)); y = int'($urandom_range(0, 127)); end
      endcase
      col = int'($urandom_range(0, 7));
      issue(x, y, col);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 10)) @(negedge clk);
        stray_start();
      end
      wait_idle();
    end

    // Reset in the middle of DRAW, after an ignored start.
    issue(m_x, m_y, 3'b001);
    repeat (3) @(negedge clk);
    stray_start();
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    #1;
    compared++;
    if (bif.busy || bif.done || bif.plot || bif.x_out != 0 || bif.y_out != 0 || bif.colour_out != 0) begin
      mismatched++;
      $display("FAIL async_reset: busy=%0b done=%0b plot=%0b x=%0d y=%0d c=%0b, required all 0",
               bif.busy, bif.done, bif.plot, bif.x_out, bif.y_out, bif.colour_out);
    end
    exp_q.delete();
    m_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);

    // Different position after reset must not erase.
    issue(40, 50, 3'b110); wait_idle();
    issue(41, 51, 3'b011); wait_idle();
    repeat (3) @(negedge clk);

    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sprite_plotter.md
SPRITE_PLOTTER -- requirements
Module: sprite_plotter

Interface
REQ-001 Parameter SPR_W, default 4: sprite width in pixels (power of two, 1..8).
REQ-002 Parameter SPR_H, default 4: sprite height in pixels (power of two, 1..8).
REQ-003 Parameter BG_COLOUR, default 3'b000: colour written when erasing.
REQ-004 Parameter X_MAX, default 159; Y_MAX, default 119: last visible column/row of the 160x120 frame buffer.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 resetn  in  1  asynchronous, active-high reset (asserted = 1), despite the name.
REQ-007 start  in  1  request to move/redraw sprite; sampled only in IDLE.
REQ-008 x_new  in  8  new sprite top-left column.
REQ-009 y_new  in  7  new sprite top-left row.
REQ-010 colour_new  in  3  new sprite colour.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 done  out  1  one-cycle pulse when a request completes.
REQ-013 x_out  out  8  pixel column to the VGA adapter.
REQ-014 y_out  out  7  pixel row to the VGA adapter.
REQ-015 colour_out  out  3  pixel colour to the VGA adapter.
REQ-016 plot  out  1  write strobe to the VGA adapter; one pixel per high cycle.

Function
REQ-017 FSM states SHALL be IDLE, ERASE, DRAW, DONE; encoding is implementation-defined.
REQ-018 IDLE + start=1 SHALL latch x_new, y_new, colour_new into new-position registers in the same edge.
REQ-019 From IDLE + start, next state SHALL be ERASE if old_valid=1 and (x_new,y_new) differs from stored (x_old,y_old); otherwise DRAW.
REQ-020 ERASE SHALL step pixel index k from 0 to SPR_W*SPR_H-1, one per cycle, then go to DRAW with k cleared.
REQ-021 DRAW SHALL step k over the same range, one per cycle, then go to DONE.
REQ-022 Pixel order SHALL be raster: dx = k mod SPR_W, dy = k / SPR_W.
REQ-023 During ERASE: x_out = x_old+dx, y_out = y_old+dy, colour_out = BG_COLOUR.
REQ-024 During DRAW: x_out = x_lat+dx, y_out = y_lat+dy, colour_out = colour_lat.
REQ-025 Coordinate sums SHALL be computed 1 bit wider than the port; plot SHALL be 0 for any pixel whose sum exceeds X_MAX or Y_MAX (clipped), the cycle still consumed.
REQ-026 plot SHALL be 1 for every unclipped pixel cycle in ERASE/DRAW and 0 in IDLE and DONE.
REQ-027 DONE SHALL last exactly one cycle: done=1, x_old/y_old <= latched position, old_valid <= 1, then IDLE.
REQ-028 start while busy=1 SHALL be ignored, not queued; inputs x_new/y_new/colour_new may change freely after the accepting edge.
REQ-029 Latency: start accepted at edge N -> first pixel present in cycle N+1; done in cycle N+1+2*SPR_W*SPR_H with erase, N+1+SPR_W*SPR_H without.
REQ-030 start may be reasserted in the cycle after done (IDLE) and SHALL be accepted.
REQ-031 Outputs in IDLE and DONE: x_out, y_out, colour_out SHALL hold 0.

Reset
REQ-032 resetn=1 SHALL immediately, without a clock edge, force state IDLE, k=0, old_valid=0, x_old=0, y_old=0, latched registers 0, and all outputs 0.
REQ-033 Reset mid-ERASE/DRAW SHALL abandon the request with no done pulse; the next request after reset SHALL skip ERASE.

Verification
REQ-034 First request after reset, x_new=10, y_new=20, colour=3'b100 -> no ERASE; 16 plot cycles covering (10..13, 20..23) raster order colour 100; done in cycle N+17.
REQ-035 Second request x_new=11, y_new=20 -> 16 erase plots at (10..13,20..23) colour 000, then 16 draw plots at (11..14,20..23) colour 100; done in cycle N+33.
REQ-036 Same position repeated with colour 3'b010 -> ERASE skipped; 16 draw plots colour 010; done in cycle N+17.
REQ-037 Request x_new=158, y_new=118 -> plot=1 only for (158..159,118..119), 4 pixels; plot=0 for the other 12 cycles; total cycles unchanged.
REQ-038 start pulsed during DRAW, then resetn asserted mid-DRAW -> extra start ignored; outputs/busy go 0 asynchronously; no done; next request skips ERASE.
